fpu_wb_buffer: RTL

FPU_WB_BUFFER -- requirements
Module: fpu_wb_buffer

---
 rtl/fpu_wb_buffer.sv | 94 +++++++++
 1 files changed

// File: rtl/fpu_wb_buffer.sv
// Write-back buffer between the FPU pipeline and its two retirement routes (integer register file, memory).
// Results retire strictly in order; only the head entry is ever presented.
module fpu_wb_buffer #(
    parameter int XLEN     = 32,
    parameter int ID_WIDTH = 4,
    parameter int DEPTH    = 4
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ID_WIDTH-1:0]      in_id,
    input  logic [XLEN-1:0]          in_data,
    input  logic                     in_toMem,
    output logic                     toXreg_valid,
    input  logic                     toXreg_ready,
    output logic [XLEN-1:0]          data_toXreg,
    output logic [ID_WIDTH-1:0]      id_toXreg,
    output logic                     toMem_valid,
    input  logic                     toMem_ready,
    output logic [XLEN-1:0]          data_toMem,
    output logic [ID_WIDTH-1:0]      id_toMem,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0]     data_q   [DEPTH];
    logic [ID_WIDTH-1:0] id_q     [DEPTH];
    logic                to_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          not_empty;
    logic          head_to_mem;
    logic          push;
    logic          pop;

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    always_comb begin
        not_empty    = (count != '0);
        head_to_mem  = to_mem_q[rd_ptr];
        in_ready     = !rst && enable && (count < CW'(DEPTH));
        toXreg_valid = enable && not_empty && !head_to_mem;
        toMem_valid  = enable && not_empty && head_to_mem;
        push         = enable && in_valid && in_ready && !flush;
        pop          = ((toXreg_valid && toXreg_ready) || (toMem_valid && toMem_ready)) && !flush;
        data_toXreg  = toXreg_valid ? data_q[rd_ptr] : '0;
        id_toXreg    = toXreg_valid ? id_q[rd_ptr]   : '0;
        data_toMem   = toMem_valid  ? data_q[rd_ptr] : '0;
        id_toMem     = toMem_valid  ? id_q[rd_ptr]   : '0;
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky until reset; flush deliberately leaves it set.
    always_ff @(posedge ck or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (enable && in_valid && !in_ready && !flush)
            overflow <= 1'b1;
    end

    always_ff @(posedge ck) begin
        if (push) begin
            data_q[wr_ptr]   <= in_data;
            id_q[wr_ptr]     <= in_id;
            to_mem_q[wr_ptr] <= in_toMem;
        end
    end

endmodule
